led_display_frame_reader: RTL and testbench

//  Row source for led_display_driver_phy. Scans frame RAM (RGB888, one word per pixel) and forms
//  top/bottom half-row bit-vectors into rgb_row_t, using per-frame PWM dithering.

---
 rtl/led_display_frame_reader_pkg.sv | 34 +++
 rtl/led_display_pwm_compare.sv | 26 ++
 rtl/led_display_frame_reader.sv | 167 ++++++++++++++++
 tb/tb_led_display_frame_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_frame_reader_pkg.sv
// Shared types and geometry for the LED panel frame reader.
package led_display_package;

  localparam int NUM_ROWS   = 32;
  localparam int NUM_COLS   = 64;
  localparam int SCAN_ROWS  = NUM_ROWS / 2;
  localparam int RAM_ADDR_W = 16;
  localparam int ROW_ADDR_W = $clog2(SCAN_ROWS);
  // One read slot per pixel of a scan row pair (top and bottom interleaved).
  localparam int SLOT_W     = $clog2(2 * NUM_COLS);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    logic [NUM_COLS-1:0] red_top;
    logic [NUM_COLS-1:0] green_top;
    logic [NUM_COLS-1:0] blue_top;
    logic [NUM_COLS-1:0] red_bot;
    logic [NUM_COLS-1:0] green_bot;
    logic [NUM_COLS-1:0] blue_bot;
  } rgb_row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } frame_reader_state_t;

endpackage

// File: rtl/led_display_pwm_compare.sv
// Turns one RGB888 pixel into three on/off bits for the current PWM level.
module led_display_pwm_compare
  import led_display_package::*;
#(
  parameter int PWM_BITS = 4
) (
  input  pixel_t              pixel_in,
  input  logic [PWM_BITS-1:0] pwm_level_in,
  output logic [2:0]          rgb_bits_out
);

  logic [7:0] r_msb;
  logic [7:0] g_msb;
  logic [7:0] b_msb;

  // Only the top PWM_BITS of each channel take part; shifting keeps the compare unsigned.
  always_comb begin
    r_msb = pixel_in.r >> (8 - PWM_BITS);
    g_msb = pixel_in.g >> (8 - PWM_BITS);
    b_msb = pixel_in.b >> (8 - PWM_BITS);
    rgb_bits_out[2] = r_msb > 8'(pwm_level_in);
    rgb_bits_out[1] = g_msb > 8'(pwm_level_in);
    rgb_bits_out[0] = b_msb > 8'(pwm_level_in);
  end

endmodule

// File: rtl/led_display_frame_reader.sv
// Scans frame RAM into top/bottom half-row bit vectors and offers them on valid/ready,
// prefetching the next row into a build register while the presented row waits.
module led_display_frame_reader
  import led_display_package::*;
#(
  parameter int PWM_BITS = 4
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic                  enable_in,
  output logic                  ram_enable_out,
  output logic [RAM_ADDR_W-1:0] ram_addr_out,
  input  logic [23:0]           ram_data_in,
  output rgb_row_t              row_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [ROW_ADDR_W-1:0] row_address_out,
  output logic                  frame_start_out
);

  localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(2 * NUM_COLS - 1);
  localparam logic [ROW_ADDR_W-1:0] LAST_ROW  = ROW_ADDR_W'(SCAN_ROWS - 1);

  frame_reader_state_t   state_q, state_d;
  logic [SLOT_W-1:0]     rd_idx_q, rd_idx_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [SLOT_W-1:0]     rd_slot_q, rd_slot_d;
  logic [ROW_ADDR_W-1:0] fetch_row_q, fetch_row_d;
  logic [PWM_BITS-1:0]   pwm_level_q, pwm_level_d;
  rgb_row_t              build_q, build_d;
  rgb_row_t              out_row_q, out_row_d;
  logic [ROW_ADDR_W-1:0] out_addr_q, out_addr_d;
  logic                  out_vld_q, out_vld_d;

  logic [2:0]            top_bits;
  logic [2:0]            bot_bits;
  logic                  transfer;
  logic                  handoff;
  logic [RAM_ADDR_W-1:0] ram_y;
  logic [NUM_COLS == 1 ? 0 : $clog2(NUM_COLS)-1:0] wr_col;

  led_display_pwm_compare #(.PWM_BITS(PWM_BITS)) u_cmp_top (
    .pixel_in     (pixel_t'(ram_data_in)),
    .pwm_level_in (pwm_level_q),
    .rgb_bits_out (top_bits)
  );

  led_display_pwm_compare #(.PWM_BITS(PWM_BITS)) u_cmp_bot (
    .pixel_in     (pixel_t'(ram_data_in)),
    .pwm_level_in (pwm_level_q),
    .rgb_bits_out (bot_bits)
  );

  // RAM address: even slots read the top half, odd slots the matching bottom-half row.
  always_comb begin
    ram_enable_out = (state_q == ST_FETCH);
    ram_y = RAM_ADDR_W'(fetch_row_q) + (rd_idx_q[0] ? RAM_ADDR_W'(SCAN_ROWS) : '0);
    ram_addr_out = '0;
    if (ram_enable_out) begin
      ram_addr_out = ram_y * RAM_ADDR_W'(NUM_COLS) + RAM_ADDR_W'(rd_idx_q[SLOT_W-1:1]);
    end
  end

  // Row interface driven straight from the output register.
  always_comb begin
    row_out         = out_row_q;
    row_valid_out   = out_vld_q;
    row_address_out = out_addr_q;
    transfer        = out_vld_q & row_ready_in;
    frame_start_out = transfer & (out_addr_q == '0);
    handoff         = (state_q == ST_DONE) & (~out_vld_q | transfer);
    wr_col          = rd_slot_q[SLOT_W-1:1];
  end

  // Fetch sequencing, build assembly and build-to-output handoff.
  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    rd_vld_d    = 1'b0;
    rd_slot_d   = rd_slot_q;
    fetch_row_d = fetch_row_q;
    pwm_level_d = pwm_level_q;
    build_d     = build_q;
    out_row_d   = out_row_q;
    out_addr_d  = out_addr_q;
    out_vld_d   = out_vld_q;

    // Read data lands one clock after its address; place it at its column.
    if (rd_vld_q) begin
      if (rd_slot_q[0]) begin
        build_d.red_bot[wr_col]   = bot_bits[2];
        build_d.green_bot[wr_col] = bot_bits[1];
        build_d.blue_bot[wr_col]  = bot_bits[0];
      end else begin
        build_d.red_top[wr_col]   = top_bits[2];
        build_d.green_top[wr_col] = top_bits[1];
        build_d.blue_top[wr_col]  = top_bits[0];
      end
    end

    if (transfer) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_in) begin
          state_d  = ST_FETCH;
          rd_idx_d = '0;
        end
      end
      ST_FETCH: begin
        rd_vld_d  = 1'b1;
        rd_slot_d = rd_idx_q;
        rd_idx_d  = rd_idx_q + SLOT_W'(1);
        if (rd_idx_q == LAST_SLOT) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        // The last read is compared at the old level, so the whole frame shares one level.
        if (fetch_row_q == LAST_ROW) begin
          pwm_level_d = pwm_level_q + PWM_BITS'(1);
        end
      end
      ST_DONE: begin
        if (handoff) begin
          state_d     = ST_IDLE;
          fetch_row_d = fetch_row_q + ROW_ADDR_W'(1);
          out_row_d   = build_q;
          out_addr_d  = fetch_row_q;
          out_vld_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset returns everything to an empty, idle reader.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q     <= ST_IDLE;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_slot_q   <= '0;
      fetch_row_q <= '0;
      pwm_level_q <= '0;
      build_q     <= '0;
      out_row_q   <= '0;
      out_addr_q  <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      rd_vld_q    <= rd_vld_d;
      rd_slot_q   <= rd_slot_d;
      fetch_row_q <= fetch_row_d;
      pwm_level_q <= pwm_level_d;
      build_q     <= build_d;
      out_row_q   <= out_row_d;
      out_addr_q  <= out_addr_d;
      out_vld_q   <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_led_display_frame_reader.sv
// Bench for led_display_frame_reader: RAM model, frame-level reference model, directed scenarios.
module tb_led_display_frame_reader;
  import led_display_package::*;

  localparam int PWM_BITS = 4;
  localparam int NPIX     = NUM_ROWS * NUM_COLS;

  logic            clk = 1'b0;
  logic            n_reset = 1'b1;
  logic            enable = 1'b0;
  logic            ram_enable;
  logic [15:0]     ram_addr;
  logic [23:0]     ram_q = '0;
  rgb_row_t        row;
  logic            valid;
  logic            ready = 1'b0;
  logic [3:0]      raddr;
  logic            fs;

  logic [23:0]     mem [0:NPIX-1];

  int n_pass = 0;
  int n_total = 0;
  int xfer_cnt = 0;
  int test_id = 0;
  int last_addr = -1;
  int last_fs = -1;

  always #5 clk = ~clk;

  led_display_frame_reader #(.PWM_BITS(PWM_BITS)) dut (
    .clk_in          (clk),
    .n_reset_in      (n_reset),
    .enable_in       (enable),
    .ram_enable_out  (ram_enable),
    .ram_addr_out    (ram_addr),
    .ram_data_in     (ram_q),
    .row_out         (row),
    .row_valid_out   (valid),
    .row_ready_in    (ready),
    .row_address_out (raddr),
    .frame_start_out (fs)
  );

  // Synchronous RAM with one clock of read latency.
  always @(posedge clk) if (ram_enable) ram_q <= mem[ram_addr[10:0]];

  task automatic chk_i(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_row(input string name, input rgb_row_t act, input rgb_row_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic lit(input logic [7:0] c, input int level);
    return int'(c >> (8 - PWM_BITS)) > level;
  endfunction

  // Expected row from the frame contents: bit x of each vector is column x of that half.
  function automatic rgb_row_t model_row(input int srow, input int level);
    rgb_row_t r;
    logic [23:0] t;
    logic [23:0] b;
    r = '0;
    for (int x = 0; x < NUM_COLS; x++) begin
      t = mem[11'(srow * NUM_COLS + x)];
      b = mem[11'((srow + SCAN_ROWS) * NUM_COLS + x)];
      r.red_top[6'(x)]   = lit(t[23:16], level);
      r.green_top[6'(x)] = lit(t[15:8], level);
      r.blue_top[6'(x)]  = lit(t[7:0], level);
      r.red_bot[6'(x)]   = lit(b[23:16], level);
      r.green_bot[6'(x)] = lit(b[15:8], level);
      r.blue_bot[6'(x)]  = lit(b[7:0], level);
    end
    return r;
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk_i({tag, "_ram_en"}, int'(ram_enable), 0);
    chk_i({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk_i({tag, "_valid"}, int'(valid), 0);
    chk_i({tag, "_row_addr"}, int'(raddr), 0);
    chk_i({tag, "_frame_start"}, int'(fs), 0);
    chk_row({tag, "_row"}, row, '0);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk_i("xfer_count_reached", int'(xfer_cnt >= target), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    n_reset = 1'b0;
    enable = 1'b0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset(input logic en, input logic rdy);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    enable = en;
    ready = rdy;
  endtask

  task automatic fill_gradient();
    for (int i = 0; i < NPIX; i++) mem[11'(i)] = {8'(i * 7), 8'(i * 13), 8'(i * 29 + 5)};
  endtask

  // Per-cycle compare: the k-th row after reset is scan row k%16 at PWM level (k/16)%16.
  initial begin
    rgb_row_t prev_row;
    logic prev_vld;
    logic prev_rdy;
    logic [3:0] prev_addr;
    int srow;
    int level;
    prev_row = '0;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        xfer_cnt = 0;
        prev_vld = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (prev_vld && !prev_rdy) begin
          chk_i("hold_valid", int'(valid), 1);
          chk_i("hold_addr", int'(raddr), int'(prev_addr));
          chk_row("hold_row", row, prev_row);
        end
        if (ram_enable) chk_i("ram_addr_range", int'(ram_addr < 16'(NPIX)), 1);
        if (valid && ready) begin
          srow = xfer_cnt % SCAN_ROWS;
          level = (xfer_cnt / SCAN_ROWS) % (1 << PWM_BITS);
          chk_i("row_addr", int'(raddr), srow);
          chk_i("frame_start", int'(fs), int'(srow == 0));
          chk_row("row_data", row, model_row(srow, level));
          if (test_id == 1 && level == 0) chk_row("white_row_l0", row, '1);
          if (test_id == 2 && srow == 3) begin
            case (level)
              0: chk_row("pix_row3_l0", row, {64'h20, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0000_0000_0000});
              8: chk_row("pix_row3_l8", row, {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0000_0000_0000});
              14: chk_row("pix_row3_l14", row, {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0000_0000_0000});
              15: chk_row("pix_row3_l15", row, '0);
              default: ;
            endcase
          end
          last_addr = int'(raddr);
          last_fs = int'(fs);
          xfer_cnt++;
        end else begin
          chk_i("frame_start_idle", int'(fs), 0);
        end
        prev_vld = valid;
        prev_rdy = ready;
        prev_row = row;
        prev_addr = raddr;
      end
    end
  end

  initial begin
    int n;
    int en_cnt;
    logic hit;

    for (int i = 0; i < NPIX; i++) mem[11'(i)] = 24'hFF_FFFF;
    #2 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");

    // All-white frames: every vector all ones for levels 0..2.
    test_id = 1;
    release_reset(1'b1, 1'b1);
    wait_xfers(3 * SCAN_ROWS, 3 * SCAN_ROWS * 140 + 200);

    // Single top pixel and single bottom pixel across a full 16-level PWM cycle.
    do_reset();
    for (int i = 0; i < NPIX; i++) mem[11'(i)] = 24'h0;
    mem[11'(3 * NUM_COLS + 5)] = 24'h80_0000;
    mem[11'(19 * NUM_COLS + 63)] = 24'h00_00F0;
    test_id = 2;
    release_reset(1'b1, 1'b1);
    wait_xfers(16 * SCAN_ROWS, 16 * SCAN_ROWS * 140 + 200);

    // Back-pressure: one row presented, exactly one prefetch, then the reader stops.
    do_reset();
    fill_gradient();
    test_id = 3;
    release_reset(1'b1, 1'b0);
    n = 0;
    while (!valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_i("stall_valid_rose", int'(valid), 1);
    en_cnt = 0;
    repeat (500) begin
      @(posedge clk);
      #1;
      if (ram_enable) en_cnt++;
    end
    chk_i("stall_prefetch_reads", en_cnt, 2 * NUM_COLS);
    chk_i("stall_ram_idle", int'(ram_enable), 0);
    chk_i("stall_no_xfer", xfer_cnt, 0);
    ready = 1'b1;
    @(negedge clk);
    chk_i("b2b_first_valid", int'(valid), 1);
    chk_i("b2b_first_addr", int'(raddr), 0);
    @(negedge clk);
    chk_i("b2b_second_valid", int'(valid), 1);
    chk_i("b2b_second_addr", int'(raddr), 1);

    // enable dropped 10 reads into the first fetch: that row completes and is delivered.
    do_reset();
    fill_gradient();
    test_id = 4;
    release_reset(1'b1, 1'b1);
    en_cnt = 0;
    repeat (700) begin
      @(posedge clk);
      #1;
      if (ram_enable) en_cnt++;
      if (en_cnt == 10) enable = 1'b0;
    end
    chk_i("endrop_reads", en_cnt, 2 * NUM_COLS);
    chk_i("endrop_xfers", xfer_cnt, 1);
    chk_i("endrop_ram_idle", int'(ram_enable), 0);
    chk_i("endrop_valid_low", int'(valid), 0);

    // Async reset while scan row 7 is being fetched.
    do_reset();
    fill_gradient();
    test_id = 5;
    release_reset(1'b1, 1'b1);
    wait_xfers(7, 7 * 140 + 200);
    n = 0;
    hit = 1'b0;
    while (!hit && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      hit = ram_enable && ram_addr >= 16'(7 * NUM_COLS) && ram_addr < 16'(8 * NUM_COLS);
    end
    chk_i("row7_fetch_seen", int'(hit), 1);
    #2 n_reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    wait_xfers(1, 300);
    chk_i("after_reset_addr", last_addr, 0);
    chk_i("after_reset_frame_start", last_fs, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
